reg_wr_sched: RTL and testbench
===============================

Name: reg_wr_sched

Overview:
- Write-scheduling stage directly upstream of the 8-bit register bank.
- Accepts register-write requests (address + data) from the execute stage through a valid/ready handshake and buffers them in a small in-order queue.
- Issues at most one write per cycle to the bank as a one-hot chosen vector plus w_en/w_data, which feed each register's chosen/w_en/w_data inputs directly.
- Provides a newest-wins read bypass so readers see writes still queued.

Parameters:
- NUM_REGS, 8, number of registers in the bank; width of chosen.
- DATA_W, 8, register data width.
- ADDR_W, 3, register address width; must satisfy 2**ADDR_W >= NUM_REGS.
- DEPTH, 4, queue entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  write request present.
- in_ready  out  1  queue can accept; equals !full, depends only on state.
- in_addr  in  ADDR_W  target register index.
- in_data  in  DATA_W  write data.
- stall  in  1  bank not writable this cycle; suppresses issue.
- chosen  out  NUM_REGS  one-hot select of head entry; all zero when not issuing.
- w_en  out  1  write strobe to bank.
- w_data  out  DATA_W  head entry data.
- rd_addr  in  ADDR_W  bypass lookup address.
- byp_hit  out  1  a queued entry targets rd_addr.
- byp_data  out  DATA_W  data of newest matching queued entry; 0 when no hit.
- count  out  $clog2(DEPTH+1)  entries queued.
- err  out  1  sticky illegal-address flag.

Behaviour:
- Reset (rst low, async): queue empty, count=0, in_ready=1, w_en=0, chosen=0, w_data=0, byp_hit=0, byp_data=0, err=0, state=IDLE. A reset mid-operation discards all queued writes; no partial write is issued.
- Accept: a push occurs on an edge where in_valid & in_ready & (in_addr < NUM_REGS). The entry is appended at the tail.
- Illegal address: in_valid & in_ready & in_addr >= NUM_REGS drops the request and sets err=1 until reset. in_ready is unaffected.
- Issue (combinational from head): w_en = !empty & !stall. Under that condition chosen = 1<<head.addr and w_data = head.data; otherwise chosen=0 and w_data=0. The head pops on the edge where w_en=1.
- Latency: a request accepted at edge k drives w_en during cycle k+1 if stall=0, and the bank captures it at edge k+1.
- Simultaneous push and pop: count is unchanged and pointers both advance. When full, no push is allowed even with a concurrent pop.
- Empty: no issue. A push into an empty queue is never issued in the same cycle.
- Order: strictly FIFO. Pointers wrap modulo DEPTH.
- count: incremented on push only, decremented on pop only. Never exceeds DEPTH or underflows.
- Bypass: combinational scan over valid entries. The entry closest to the tail with addr==rd_addr wins. This includes the head even while it is being issued.
- State machine (state is observable only via w_en):
  - IDLE: count=0. A push goes to ACTIVE.
  - ACTIVE: count>0 and stall=0, issuing. stall=1 goes to HOLD. A pop of the last entry with no push goes to IDLE.
  - HOLD: count>0 and stall=1, w_en=0, pushes still accepted. stall=0 goes to ACTIVE.

Optional Feature:
- Macro REGWR_COALESCE_EN.
- When defined: a legal push whose addr equals the newest queued entry's addr overwrites that entry's data instead of appending, and count is unchanged.
  - Coalescing is not allowed when that entry is the head being popped the same cycle; the request appends normally instead.
  - Accepted when full only if coalescing; in_ready = !full | (in_valid & addr match & !head-pop case).
- When undefined: every legal push appends; in_ready = !full.

Decomposition:
- Package reg_wr_pkg holds:
  - the entry struct {addr, data};
  - the state enum {IDLE, ACTIVE, HOLD};
  - default constants for NUM_REGS/DATA_W/ADDR_W/DEPTH.
- Sub-module reg_wr_fifo holds the storage array, pointers and count, and exposes its entry array for the bypass scan.
- Decode, issue, bypass and state logic stay in reg_wr_sched.

Test Plan:
- Reset with rst=0 mid-stream (3 entries queued) -> count=0, w_en=0, chosen=0 immediately; no write issued after rst rises.
- Push addr=2 data=8'hA5 with stall=0 -> next cycle chosen=8'b0000_0100, w_en=1, w_data=8'hA5; count returns to 0.
- stall=1, push 5 requests -> 4 accepted, in_ready=0 at count=4; on release, writes issue in order, one per cycle, over 4 cycles.
- Queue addr=3/8'h11 then addr=3/8'h22 (stall=1), rd_addr=3 -> byp_hit=1, byp_data=8'h22; rd_addr=4 -> byp_hit=0, byp_data=0.
- With NUM_REGS=6, push addr=7 -> request dropped, err=1 and stays 1, count unchanged.
- REGWR_COALESCE_EN defined, stall=1, push addr=1/8'h01 then addr=1/8'h02 -> count=1; after release one write with w_data=8'h02.

Source files
------------

// File: rtl/reg_wr_pkg.sv
// Shared types and default sizing for the register-write scheduler.
// Queue entries use the default address/data widths defined here.
package reg_wr_pkg;

    localparam int NUM_REGS_DEF = 8;
    localparam int DATA_W_DEF   = 8;
    localparam int ADDR_W_DEF   = 3;
    localparam int DEPTH_DEF    = 4;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wr_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HOLD   = 2'd2
    } sched_state_t;

endpackage

// File: rtl/reg_wr_sched_if.sv
// Request, issue and bypass signals between the execute stage, the
// write scheduler and the register bank.
interface reg_wr_sched_if
    import reg_wr_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DEPTH    = DEPTH_DEF
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                in_valid;
    logic                in_ready;
    logic [ADDR_W-1:0]   in_addr;
    logic [DATA_W-1:0]   in_data;
    logic                stall;
    logic [NUM_REGS-1:0] chosen;
    logic                w_en;
    logic [DATA_W-1:0]   w_data;
    logic [ADDR_W-1:0]   rd_addr;
    logic                byp_hit;
    logic [DATA_W-1:0]   byp_data;
    logic [CNT_W-1:0]    count;
    logic                err;

    modport master (
        output in_valid, in_addr, in_data, stall, rd_addr,
        input  in_ready, chosen, w_en, w_data, byp_hit, byp_data, count, err
    );

    modport slave (
        input  in_valid, in_addr, in_data, stall, rd_addr,
        output in_ready, chosen, w_en, w_data, byp_hit, byp_data, count, err
    );

endinterface

// File: rtl/reg_wr_fifo.sv
// In-order write queue: storage, head/tail pointers and occupancy.
// The whole entry array is exported so the scheduler can scan it for
// read bypass. An overwrite port updates the newest entry's data in place.
module reg_wr_fifo
    import reg_wr_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  wr_entry_t             push_entry,
    input  logic                  ovr,
    input  logic [DATA_W_DEF-1:0] ovr_data,
    input  logic                  pop,
    output wr_entry_t             entries [DEPTH],
    output wr_entry_t             head_entry,
    output logic [PTR_W-1:0]      tail,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty
);

    wr_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] newest_idx;

    assign newest_idx = tail - 1'b1;
    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign head_entry = mem[head];
    assign entries    = mem;

    // Storage, pointers and count; pointers wrap naturally (DEPTH is 2**n).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_entry;
                tail      <= tail + 1'b1;
            end else if (ovr) begin
                mem[newest_idx].data <= ovr_data;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/reg_wr_sched.sv
// Register-write scheduler: queues execute-stage writes and issues one per
// cycle to the register bank as a one-hot select, with newest-wins bypass.
// Build option REGWR_COALESCE_EN: a push to the same address as the newest
// queued entry overwrites that entry's data instead of appending.
//
// state  | meaning
// IDLE   | queue empty, nothing to issue
// ACTIVE | entries queued, bank writable, head issuing
// HOLD   | entries queued, bank stalled, pushes still accepted
module reg_wr_sched
    import reg_wr_pkg::*;
#(
    parameter  int NUM_REGS = NUM_REGS_DEF,
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int ADDR_W   = ADDR_W_DEF,
    parameter  int DEPTH    = DEPTH_DEF,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input logic           clk,
    input logic           rst,
    reg_wr_sched_if.slave bus
);

    sched_state_t     state, state_nxt;
    wr_entry_t        entries [DEPTH];
    wr_entry_t        head_entry;
    wr_entry_t        push_entry;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             full, empty;
    logic             addr_legal, accept, push, pop, coalesce;
    logic             in_ready, w_en, err;

    assign addr_legal = (int'(bus.in_addr) < NUM_REGS);

    // Pop of the only entry this cycle: the newest entry is leaving, so a
    // same-address request must append rather than merge into it.
    logic head_pop_last;
    assign head_pop_last = pop && (count == CNT_W'(1));

`ifdef REGWR_COALESCE_EN
    logic tail_match;
    assign tail_match = !empty && (entries[tail - 1'b1].addr == bus.in_addr)
                        && !head_pop_last;
    assign in_ready   = !full || (bus.in_valid && tail_match);
    assign coalesce   = bus.in_valid && in_ready && addr_legal && tail_match;
`else
    assign in_ready   = !full;
    assign coalesce   = 1'b0;
`endif

    assign accept     = bus.in_valid && in_ready;
    assign push       = accept && addr_legal && !coalesce;
    assign push_entry = '{addr: bus.in_addr, data: bus.in_data};

    // Issue is gated by state so nothing leaves the queue in the cycle an
    // entry first lands in an empty queue, nor right after reset.
    assign w_en = (state != IDLE) && !bus.stall;
    assign pop  = w_en;

    reg_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .ovr        (coalesce),
        .ovr_data   (bus.in_data),
        .pop        (pop),
        .entries    (entries),
        .head_entry (head_entry),
        .tail       (tail),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: draining the last entry returns to IDLE, otherwise stall
    // selects between HOLD and ACTIVE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (push) state_nxt = ACTIVE;
            end
            ACTIVE, HOLD: begin
                if (head_pop_last && !push) state_nxt = IDLE;
                else if (bus.stall)         state_nxt = HOLD;
                else                        state_nxt = ACTIVE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sticky illegal-address flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (accept && !addr_legal) begin
            err <= 1'b1;
        end
    end

    // Newest-wins bypass: walk from oldest to newest so the last match holds.
    always_comb begin
        bus.byp_hit  = 1'b0;
        bus.byp_data = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((CNT_W'(i) < count) &&
                (entries[tail - PTR_W'(i + 1)].addr == bus.rd_addr)) begin
                bus.byp_hit  = 1'b1;
                bus.byp_data = entries[tail - PTR_W'(i + 1)].data;
            end
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.w_en     = w_en;
    assign bus.chosen   = w_en ? (NUM_REGS'(1) << head_entry.addr) : '0;
    assign bus.w_data   = w_en ? head_entry.data : '0;
    assign bus.count    = count;
    assign bus.err      = err;

endmodule

// File: tb/tb_reg_wr_sched.sv
// Bench for reg_wr_sched: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_reg_wr_sched;
    import reg_wr_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_wr_sched_if #(.NUM_REGS(8), .DATA_W(8), .ADDR_W(3), .DEPTH(DEPTH)) bus ();
    reg_wr_sched_if #(.NUM_REGS(6), .DATA_W(8), .ADDR_W(3), .DEPTH(DEPTH)) bus6 ();

    reg_wr_sched #(.NUM_REGS(8), .DATA_W(8), .ADDR_W(3), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    reg_wr_sched #(.NUM_REGS(6), .DATA_W(8), .ADDR_W(3), .DEPTH(DEPTH)) dut6 (
        .clk (clk),
        .rst (rst),
        .bus (bus6)
    );

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
    } ment_t;

    typedef struct {
        bit         v;
        logic [2:0] a;
        logic [7:0] d;
        bit         s;
        logic [2:0] r;
        bit         e_wen;
        logic [7:0] e_ch;
        logic [7:0] e_wd;
        int         e_cnt;
        bit         e_rdy;
        bit         e_hit;
        logic [7:0] e_byp;
    } vec_t;

    ment_t mq[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [2:0] a, input logic [7:0] d,
                         input bit s, input logic [2:0] r);
        bus.in_valid = v;
        bus.in_addr  = a;
        bus.in_data  = d;
        bus.stall    = s;
        bus.rd_addr  = r;
    endtask

    // Would the current request merge into the newest queued entry.
    function automatic bit model_merge(input bit wen);
`ifdef REGWR_COALESCE_EN
        return (mq.size() > 0) && (mq[$].addr == bus.in_addr) &&
               !(wen && mq.size() == 1);
`else
        return wen && 1'b0;
`endif
    endfunction

    // Compare all outputs against the model for the inputs now on the bus,
    // then advance the model across one rising edge.
    task automatic model_cycle();
        bit         wen, rdy, hit, merge;
        logic [7:0] ch, wd, bd;
        wen   = (mq.size() > 0) && !bus.stall;
        ch    = wen ? (8'(1) << mq[0].addr) : 8'h00;
        wd    = wen ? mq[0].data : 8'h00;
        merge = model_merge(wen);
        rdy   = (mq.size() < DEPTH) || (bus.in_valid && merge);
        hit   = 1'b0;
        bd    = 8'h00;
        foreach (mq[i]) begin
            if (mq[i].addr == bus.rd_addr) begin
                hit = 1'b1;
                bd  = mq[i].data;
            end
        end
        chk("m_w_en",     32'(bus.w_en),     32'(wen));
        chk("m_chosen",   32'(bus.chosen),   32'(ch));
        chk("m_w_data",   32'(bus.w_data),   32'(wd));
        chk("m_count",    32'(bus.count),    32'(mq.size()));
        chk("m_in_ready", 32'(bus.in_ready), 32'(rdy));
        chk("m_byp_hit",  32'(bus.byp_hit),  32'(hit));
        chk("m_byp_data", 32'(bus.byp_data), 32'(bd));
        chk("m_err",      32'(bus.err),      32'd0);
        @(posedge clk);
        if (bus.in_valid && rdy) begin
            if (merge) mq[$].data = bus.in_data;
            else       mq.push_back('{addr: bus.in_addr, data: bus.in_data});
        end
        if (wen) void'(mq.pop_front());
        @(negedge clk);
    endtask

    task automatic step(input bit v, input logic [2:0] a, input logic [7:0] d,
                        input bit s, input logic [2:0] r);
        drive(v, a, d, s, r);
        #1;
        model_cycle();
    endtask

    task automatic drive6(input bit v, input logic [2:0] a, input bit s);
        bus6.in_valid = v;
        bus6.in_addr  = a;
        bus6.in_data  = 8'h99;
        bus6.stall    = s;
        bus6.rd_addr  = 3'd0;
    endtask

    vec_t vecs[17];

    initial begin
        vecs[0]  = '{1, 3'd2, 8'hA5, 0, 3'd2, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00};
        vecs[1]  = '{0, 3'd0, 8'h00, 0, 3'd2, 1, 8'h04, 8'hA5, 1, 1, 1, 8'hA5};
        vecs[2]  = '{0, 3'd0, 8'h00, 1, 3'd3, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00};
        vecs[3]  = '{1, 3'd3, 8'h11, 1, 3'd3, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00};
        vecs[4]  = '{1, 3'd5, 8'h66, 1, 3'd3, 0, 8'h00, 8'h00, 1, 1, 1, 8'h11};
        vecs[5]  = '{1, 3'd3, 8'h22, 1, 3'd5, 0, 8'h00, 8'h00, 2, 1, 1, 8'h66};
        vecs[6]  = '{1, 3'd7, 8'h44, 1, 3'd3, 0, 8'h00, 8'h00, 3, 1, 1, 8'h22};
        vecs[7]  = '{1, 3'd1, 8'h55, 1, 3'd7, 0, 8'h00, 8'h00, 4, 0, 1, 8'h44};
        vecs[8]  = '{0, 3'd0, 8'h00, 0, 3'd1, 1, 8'h08, 8'h11, 4, 0, 0, 8'h00};
        vecs[9]  = '{0, 3'd0, 8'h00, 0, 3'd3, 1, 8'h20, 8'h66, 3, 1, 1, 8'h22};
        vecs[10] = '{0, 3'd0, 8'h00, 0, 3'd3, 1, 8'h08, 8'h22, 2, 1, 1, 8'h22};
        vecs[11] = '{0, 3'd0, 8'h00, 0, 3'd7, 1, 8'h80, 8'h44, 1, 1, 1, 8'h44};
        vecs[12] = '{0, 3'd0, 8'h00, 0, 3'd7, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00};
        vecs[13] = '{1, 3'd6, 8'h77, 0, 3'd6, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00};
        vecs[14] = '{1, 3'd4, 8'h88, 0, 3'd6, 1, 8'h40, 8'h77, 1, 1, 1, 8'h77};
        vecs[15] = '{0, 3'd0, 8'h00, 0, 3'd4, 1, 8'h10, 8'h88, 1, 1, 1, 8'h88};
        vecs[16] = '{0, 3'd0, 8'h00, 0, 3'd4, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00};

        drive(0, 3'd0, 8'h00, 0, 3'd0);
        drive6(0, 3'd0, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_count",  32'(bus.count),    32'd0);
        chk("rst_ready",  32'(bus.in_ready), 32'd1);
        chk("rst_w_en",   32'(bus.w_en),     32'd0);
        chk("rst_err",    32'(bus.err),      32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Directed table: single write latency, fill-to-full, ordered drain,
        // bypass and push/pop in the same cycle.
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].s, vecs[i].r);
            #1;
            chk($sformatf("v%0d_w_en", i),     32'(bus.w_en),     32'(vecs[i].e_wen));
            chk($sformatf("v%0d_chosen", i),   32'(bus.chosen),   32'(vecs[i].e_ch));
            chk($sformatf("v%0d_w_data", i),   32'(bus.w_data),   32'(vecs[i].e_wd));
            chk($sformatf("v%0d_count", i),    32'(bus.count),    32'(vecs[i].e_cnt));
            chk($sformatf("v%0d_ready", i),    32'(bus.in_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_byp_hit", i),  32'(bus.byp_hit),  32'(vecs[i].e_hit));
            chk($sformatf("v%0d_byp_data", i), 32'(bus.byp_data), 32'(vecs[i].e_byp));
            model_cycle();
        end

        // Newest-wins bypass with back-to-back writes to one address.
        step(1, 3'd3, 8'h11, 1, 3'd3);
        step(1, 3'd3, 8'h22, 1, 3'd3);
        drive(0, 3'd0, 8'h00, 1, 3'd3);
        #1;
        chk("byp3_hit",  32'(bus.byp_hit),  32'd1);
        chk("byp3_data", 32'(bus.byp_data), 32'h22);
        model_cycle();
        drive(0, 3'd0, 8'h00, 1, 3'd4);
        #1;
        chk("byp4_hit",  32'(bus.byp_hit),  32'd0);
        chk("byp4_data", 32'(bus.byp_data), 32'h00);
        model_cycle();
        repeat (3) step(0, 3'd0, 8'h00, 0, 3'd0);

        // Same-address pair under stall: merged or appended by build option.
        step(1, 3'd1, 8'h01, 1, 3'd0);
        step(1, 3'd1, 8'h02, 1, 3'd0);
        drive(0, 3'd0, 8'h00, 1, 3'd0);
        #1;
`ifdef REGWR_COALESCE_EN
        chk("coal_count", 32'(bus.count), 32'd1);
`else
        chk("coal_count", 32'(bus.count), 32'd2);
`endif
        model_cycle();
        drive(0, 3'd0, 8'h00, 0, 3'd0);
        #1;
`ifdef REGWR_COALESCE_EN
        chk("coal_w_data", 32'(bus.w_data), 32'h02);
`else
        chk("coal_w_data", 32'(bus.w_data), 32'h01);
`endif
        model_cycle();
        repeat (2) step(0, 3'd0, 8'h00, 0, 3'd0);

        // Six-register bank: addresses 6 and 7 are dropped and flag err.
        drive6(1, 3'd7, 1);
        #1;
        chk("n6_err0",   32'(bus6.err),   32'd0);
        chk("n6_ready0", 32'(bus6.in_ready), 32'd1);
        @(negedge clk);
        drive6(1, 3'd5, 1);
        #1;
        chk("n6_err1",   32'(bus6.err),   32'd1);
        chk("n6_count1", 32'(bus6.count), 32'd0);
        @(negedge clk);
        drive6(1, 3'd6, 1);
        #1;
        chk("n6_count2", 32'(bus6.count), 32'd1);
        @(negedge clk);
        drive6(0, 3'd0, 0);
        #1;
        chk("n6_count3",  32'(bus6.count),  32'd1);
        chk("n6_err3",    32'(bus6.err),    32'd1);
        chk("n6_w_en",    32'(bus6.w_en),   32'd1);
        chk("n6_chosen",  32'(bus6.chosen), 32'h20);
        @(negedge clk);
        #1;
        chk("n6_count4", 32'(bus6.count), 32'd0);
        chk("n6_err4",   32'(bus6.err),   32'd1);
        @(negedge clk);

        // Reset with three entries queued: immediate clear, nothing issued after.
        step(1, 3'd2, 8'h31, 1, 3'd2);
        step(1, 3'd4, 8'h32, 1, 3'd2);
        step(1, 3'd6, 8'h33, 1, 3'd2);
        drive(0, 3'd0, 8'h00, 0, 3'd2);
        #1;
        chk("pre_rst_count", 32'(bus.count), 32'd3);
        rst = 1'b0;
        #1;
        chk("mid_rst_count",  32'(bus.count),   32'd0);
        chk("mid_rst_w_en",   32'(bus.w_en),    32'd0);
        chk("mid_rst_chosen", 32'(bus.chosen),  32'd0);
        chk("mid_rst_byp",    32'(bus.byp_hit), 32'd0);
        chk("mid_rst_err6",   32'(bus6.err),    32'd0);
        mq.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) step(0, 3'd0, 8'h00, 0, 3'd2);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 500; n++) begin
            step($urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)), 8'($urandom),
                 $urandom_range(0, 9) < 3, 3'($urandom_range(0, 7)));
        end
        repeat (6) step(0, 3'd0, 8'h00, 0, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
